// File: rtl/rdyval2reqack_tph.sv
// rtl/rdyval2reqack_tph.sv - ready/valid to two-phase req/ack bridge
// One transfer per req toggle; an ack toggle back to req frees the bridge.
module rdyval2reqack_tph #(
   parameter int DWIDTH      = 1,
   parameter bit INCLUDE_CDC = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vld,
   output logic              rdy,
   input  logic [DWIDTH-1:0] i_dat,
   output logic              req,
   input  logic              ack,
   output logic [DWIDTH-1:0] o_dat,
   output logic              err
);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t            r_state, w_state_nxt;
   logic              r_req, w_req_nxt;
   logic              r_rdy, w_rdy_nxt;
   logic              r_err, w_err_nxt;
   logic [DWIDTH-1:0] r_dat, w_dat_nxt;
   logic              w_ack_s;

   generate
      if (INCLUDE_CDC) begin : g_cdc
         logic [1:0] r_ack_sync;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) r_ack_sync <= 2'b00;
            else     r_ack_sync <= {r_ack_sync[0], ack};
         end
         assign w_ack_s = r_ack_sync[1];
      end else begin : g_no_cdc
         assign w_ack_s = ack;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_req   <= 1'b0;
         r_rdy   <= 1'b0;
         r_err   <= 1'b0;
         r_dat   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
         r_rdy   <= w_rdy_nxt;
         r_err   <= w_err_nxt;
         r_dat   <= w_dat_nxt;
      end
   end

   // An ack change while idle is a downstream violation: hold off until it matches req again.
   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = r_req;
      w_rdy_nxt   = r_rdy;
      w_err_nxt   = r_err;
      w_dat_nxt   = r_dat;
      case (r_state)
         ST_IDLE: begin
            if (w_ack_s != r_req) begin
               w_err_nxt = 1'b1;
               w_rdy_nxt = 1'b0;
            end else if (r_rdy && vld) begin
               w_dat_nxt   = i_dat;
               w_req_nxt   = ~r_req;
               w_rdy_nxt   = 1'b0;
               w_state_nxt = ST_BUSY;
            end else begin
               w_rdy_nxt = 1'b1;
            end
         end
         ST_BUSY: begin
            if (w_ack_s == r_req) begin
               w_rdy_nxt   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign rdy   = r_rdy;
   assign req   = r_req;
   assign o_dat = r_dat;
   assign err   = r_err;

endmodule

// File: tb/tb_rdyval2reqack_tph.sv
// tb/tb_rdyval2reqack_tph.sv - self-checking bench for rdyval2reqack_tph
module tb_rdyval2reqack_tph;

   typedef struct packed {
      logic       rst;
      logic       vld;
      logic [7:0] dat;
      logic       ack;
      logic       req;
      logic       rdy;
      logic [7:0] odat;
      logic       err;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst, vld, ack, req, rdy, err;
   logic [7:0] dat, odat;
   logic       rst1, vld1, ack1, req1, rdy1, err1;
   logic [7:0] dat1, odat1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rdyval2reqack_tph #(.DWIDTH(8), .INCLUDE_CDC(1'b0)) dut0 (
      .clk(clk), .rst(rst), .vld(vld), .rdy(rdy), .i_dat(dat),
      .req(req), .ack(ack), .o_dat(odat), .err(err)
   );

   rdyval2reqack_tph #(.DWIDTH(8), .INCLUDE_CDC(1'b1)) dut1 (
      .clk(clk), .rst(rst1), .vld(vld1), .rdy(rdy1), .i_dat(dat1),
      .req(req1), .ack(ack1), .o_dat(odat1), .err(err1)
   );

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b expected %0b", nm, act, exp);
      end
   endtask

   task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   vec_t       tbl [12];
   logic [7:0] words [10];
   logic [7:0] sb_q [$];
   logic [7:0] exp_w;
   logic       exp_req;
   logic       ack_pend;
   int         idx, got;

   initial begin
      rst = 1'b1; vld = 1'b0; dat = 8'h00; ack = 1'b0;
      rst1 = 1'b1; vld1 = 1'b0; dat1 = 8'h00; ack1 = 1'b0;

      //            rst   vld   dat    ack   req   rdy   odat   err
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1};

      for (int i = 0; i < 12; i++) begin
         rst = tbl[i].rst; vld = tbl[i].vld; dat = tbl[i].dat; ack = tbl[i].ack;
         step();
         chk1($sformatf("vec%0d_req", i), req, tbl[i].req);
         chk1($sformatf("vec%0d_rdy", i), rdy, tbl[i].rdy);
         chk8($sformatf("vec%0d_odat", i), odat, tbl[i].odat);
         chk1($sformatf("vec%0d_err", i), err, tbl[i].err);
      end

      // Stall: ack withheld 5 cycles while the next word waits on vld.
      rst = 1'b1; vld = 1'b0; dat = 8'h00; ack = 1'b0;
      step(); step();
      chk1("rst_clears_err", err, 1'b0);
      rst = 1'b0;
      step();
      chk1("stall_rdy_up", rdy, 1'b1);
      vld = 1'b1; dat = 8'h11;
      step();
      chk1("stall_req", req, 1'b1);
      chk8("stall_odat", odat, 8'h11);
      dat = 8'h3C;
      for (int i = 0; i < 5; i++) begin
         step();
         chk1($sformatf("stall%0d_rdy", i), rdy, 1'b0);
         chk1($sformatf("stall%0d_req", i), req, 1'b1);
         chk8($sformatf("stall%0d_odat", i), odat, 8'h11);
      end
      ack = 1'b1;
      step();
      chk1("stall_rel_rdy", rdy, 1'b1);
      chk8("stall_rel_odat", odat, 8'h11);
      step();
      chk1("stall_acc_req", req, 1'b0);
      chk8("stall_acc_odat", odat, 8'h3C);
      chk1("stall_acc_rdy", rdy, 1'b0);
      vld = 1'b0; ack = 1'b0;
      step();
      chk1("stall_done_rdy", rdy, 1'b1);
      chk1("stall_err", err, 1'b0);

      // Back-to-back with a loopback ack one cycle after each req toggle.
      for (int i = 0; i < 10; i++) words[i] = 8'($urandom_range(0, 255));
      exp_req = 1'b0; ack_pend = 1'b0; idx = 0; got = 0;
      vld = 1'b1; dat = words[0]; sb_q.push_back(words[0]);
      for (int c = 0; c < 200 && got < 10; c++) begin
         step();
         if (ack_pend) begin
            ack = ~ack;
            ack_pend = 1'b0;
         end
         if (req !== exp_req) begin
            exp_req = req;
            if (sb_q.size() == 0) begin
               chk1("b2b_unexpected_toggle", 1'b1, 1'b0);
            end else begin
               exp_w = sb_q.pop_front();
               chk8($sformatf("b2b_word%0d", got), odat, exp_w);
            end
            got++;
            ack_pend = 1'b1;
            idx++;
            if (idx < 10) begin
               dat = words[idx];
               sb_q.push_back(words[idx]);
            end else begin
               vld = 1'b0;
            end
         end
      end
      chk8("b2b_count", 8'(got), 8'd10);
      chk8("b2b_q_empty", 8'(sb_q.size()), 8'd0);
      step();
      ack = ~ack;
      step(); step(); step();
      chk1("b2b_no_extra_req", req, exp_req);
      chk1("b2b_final_rdy", rdy, 1'b1);
      chk1("b2b_err", err, 1'b0);

      // Synchronized ack: reset abort while busy, then 2-cycle longer completion.
      rst1 = 1'b0;
      step();
      chk1("cdc_rdy_up", rdy1, 1'b1);
      vld1 = 1'b1; dat1 = 8'hA5;
      step();
      chk1("cdc_req", req1, 1'b1);
      chk8("cdc_odat", odat1, 8'hA5);
      vld1 = 1'b0;
      step();
      chk1("cdc_busy_rdy", rdy1, 1'b0);
      #1 rst1 = 1'b1;
      #1;
      chk1("cdc_rst_req", req1, 1'b0);
      chk1("cdc_rst_rdy", rdy1, 1'b0);
      chk8("cdc_rst_odat", odat1, 8'h00);
      step();
      rst1 = 1'b0;
      step();
      chk1("cdc_rerdy", rdy1, 1'b1);
      vld1 = 1'b1; dat1 = 8'hA5;
      step();
      chk1("cdc2_req", req1, 1'b1);
      chk8("cdc2_odat", odat1, 8'hA5);
      vld1 = 1'b0; ack1 = 1'b1;
      step();
      chk1("cdc2_wait1_rdy", rdy1, 1'b0);
      step();
      chk1("cdc2_wait2_rdy", rdy1, 1'b0);
      step();
      chk1("cdc2_rdy", rdy1, 1'b1);
      chk1("cdc2_err", err1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/rdyval2reqack_tph.md
RDYVAL2REQACK_TPH -- requirements
Module: rdyval2reqack_tph

Interface
REQ-001 The module SHALL have a parameter DWIDTH, default 1, setting the data path bit width.
REQ-002 The module SHALL have a parameter INCLUDE_CDC, default 1'b0; when set, the ack input passes through a 2-flop synchronizer before use.
REQ-003 The module SHALL have the port clk, input, 1 bit: the single clock; all flops use its rising edge.
REQ-004 The module SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have the port vld, input, 1 bit: upstream valid.
REQ-006 The module SHALL have the port rdy, output, 1 bit: ready to upstream, registered.
REQ-007 The module SHALL have the port i_dat, input, DWIDTH bits: upstream data.
REQ-008 The module SHALL have the port req, output, 1 bit: two-phase request, registered; each toggle is one transfer.
REQ-009 The module SHALL have the port ack, input, 1 bit: two-phase acknowledge; a toggle to equal req completes a transfer.
REQ-010 The module SHALL have the port o_dat, output, DWIDTH bits: registered data that accompanies req.
REQ-011 The module SHALL have the port err, output, 1 bit: sticky protocol-violation flag, registered.

Function
REQ-012 ack_s SHALL equal ack when INCLUDE_CDC=0, and ack delayed by two clk flops when INCLUDE_CDC=1.
REQ-013 The FSM SHALL have two states: IDLE (no transfer outstanding) and BUSY (req toggled, awaiting ack_s==req).
REQ-014 rdy SHALL be 1 only in IDLE and only after the first clk edge following rst deassertion.
REQ-015 A transfer SHALL be accepted at a clk edge where vld=1 and rdy=1; at that edge o_dat<=i_dat, req<=~req, rdy<=0, state<=BUSY.
REQ-016 req and o_dat SHALL change at the same edge; o_dat SHALL hold stable from a req toggle until the next accepted transfer.
REQ-017 vld=1 with rdy=0 SHALL have no effect; upstream holds vld and i_dat until accepted.
REQ-018 In BUSY, at an edge where ack_s==req, the block SHALL set rdy<=1 and state<=IDLE.
REQ-019 With INCLUDE_CDC=0, an ack toggle settled before edge k SHALL give rdy=1 after edge k; INCLUDE_CDC=1 adds exactly 2 cycles.
REQ-020 Minimum transfer period SHALL be 2 cycles (accept, then return to IDLE on the edge seeing ack_s==req) plus the ack round-trip.
REQ-021 Back-to-back transfers SHALL be supported: vld held 1 while returning to IDLE is accepted on the first edge with rdy=1.
REQ-022 An ack_s change while in IDLE (ack_s!=req) SHALL set err<=1 and rdy<=0; the block SHALL stay non-ready without toggling req until ack_s==req again, then resume with rdy=1.
REQ-023 err SHALL remain 1 until rst.
REQ-024 A vld deassertion before acceptance (protocol violation upstream) SHALL leave req and o_dat unchanged.

Reset
REQ-025 While rst=1, outputs SHALL be req=0, rdy=0, o_dat=0, err=0, state=IDLE, and synchronizer flops=0, asynchronously on rst assertion.
REQ-026 Reset mid-transfer (BUSY) SHALL abort the transfer, leaving req=0 with no further req toggle; the downstream ack source is reset in the same domain so ack=0.
REQ-027 After rst falls, rdy SHALL rise at the first clk edge with ack_s==req(=0).

Verification (DWIDTH=8, clk period 10 ns, inputs driven 1 ns after clk rise, outputs checked 2 ns after)
REQ-028 Reset: rst=1 for 2 cycles, then 0 -> req=0, rdy=0, o_dat=00h, err=0 during reset; rdy=1 one edge after release.
REQ-029 Single transfer: vld=1, i_dat=A5h -> req=1, o_dat=A5h, rdy=0 after next edge; ack=1 -> rdy=1 after the following edge, err=0.
REQ-030 Ten back-to-back transfers of random data with vld held 1: a loopback model toggles ack one cycle after req -> each req toggle carries the matching o_dat, with no lost or duplicated words.
REQ-031 Stall: hold ack for 5 cycles after a req toggle while vld=1, i_dat=3Ch -> rdy stays 0, req and o_dat stay unchanged, and 3Ch is accepted one edge after rdy=1.
REQ-032 Spurious ack: toggle ack while in IDLE -> err=1 and rdy=0; restore ack==req -> rdy=1, err stays 1.
REQ-033 INCLUDE_CDC=1: repeat REQ-029 -> rdy rises exactly 2 cycles later than with INCLUDE_CDC=0; a rst pulse while BUSY -> req=0, rdy=0 immediately.
